// File: rtl/unidade_controle_rodada.sv
// rtl/unidade_controle_rodada.sv - Moore FSM sequencing one game round with a move timeout
module unidade_controle_rodada #(
  parameter int          TIMEOUT_CYCLES = 5000,
  parameter logic [3:0]  START_POS      = 4'd0
) (
  input  logic       i_clock,
  input  logic       i_clr,
  input  logic       i_iniciar,
  input  logic       i_jogada,
  input  logic       i_acertou,
  input  logic       i_fim_seq,
  input  logic       i_meio_seq,
  input  logic       i_modo_meio,
  output logic       o_cont_clr,
  output logic       o_cont_ld,
  output logic [3:0] o_cont_D,
  output logic       o_cont_en,
  output logic       o_registra,
  output logic       o_pronto,
  output logic       o_ganhou,
  output logic       o_perdeu,
  output logic       o_timeout,
  output logic [3:0] o_db_estado
);

  typedef enum logic [3:0] {
    S_INICIAL     = 4'h0,
    S_PREPARACAO  = 4'h1,
    S_ESPERA      = 4'h2,
    S_REGISTRA    = 4'h3,
    S_COMPARACAO  = 4'h4,
    S_PROXIMO     = 4'h5,
    S_FIM_ACERTO  = 4'hA,
    S_FIM_ERRO    = 4'hE,
    S_FIM_TIMEOUT = 4'hF
  } estado_t;

  localparam logic [15:0] LP_TIMER_ULTIMO = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] LP_TIMER_MAX    = 16'hFFFF;

  estado_t     r_estado;
  estado_t     w_proximo;
  logic [15:0] r_timer;
  logic        w_timer_expirou;
  logic        w_fim_rodada;

  assign w_timer_expirou = (r_timer == LP_TIMER_ULTIMO);
  assign w_fim_rodada    = i_modo_meio ? i_meio_seq : i_fim_seq;

  always_ff @(posedge i_clock or negedge i_clr) begin
    if (!i_clr) begin
      r_estado <= S_INICIAL;
    end else begin
      r_estado <= w_proximo;
    end
  end

  // Timer only advances in espera and saturates so a huge TIMEOUT_CYCLES never wraps.
  always_ff @(posedge i_clock or negedge i_clr) begin
    if (!i_clr) begin
      r_timer <= 16'd0;
    end else if (r_estado == S_PREPARACAO) begin
      r_timer <= 16'd0;
    end else if (r_estado == S_ESPERA) begin
      if (i_jogada) begin
        r_timer <= 16'd0;
      end else if (r_timer != LP_TIMER_MAX) begin
        r_timer <= r_timer + 16'd1;
      end
    end
  end

  always_comb begin
    w_proximo = S_INICIAL;
    case (r_estado)
      S_INICIAL:     w_proximo = i_iniciar ? S_PREPARACAO : S_INICIAL;
      S_PREPARACAO:  w_proximo = S_ESPERA;
      S_ESPERA: begin
        if (i_jogada) begin
          w_proximo = S_REGISTRA;
        end else if (w_timer_expirou) begin
          w_proximo = S_FIM_TIMEOUT;
        end else begin
          w_proximo = S_ESPERA;
        end
      end
      S_REGISTRA:    w_proximo = S_COMPARACAO;
      S_COMPARACAO: begin
        if (!i_acertou) begin
          w_proximo = S_FIM_ERRO;
        end else if (w_fim_rodada) begin
          w_proximo = S_FIM_ACERTO;
        end else begin
          w_proximo = S_PROXIMO;
        end
      end
      S_PROXIMO:     w_proximo = S_ESPERA;
      S_FIM_ACERTO:  w_proximo = i_iniciar ? S_PREPARACAO : S_FIM_ACERTO;
      S_FIM_ERRO:    w_proximo = i_iniciar ? S_PREPARACAO : S_FIM_ERRO;
      S_FIM_TIMEOUT: w_proximo = i_iniciar ? S_PREPARACAO : S_FIM_TIMEOUT;
      default:       w_proximo = S_INICIAL;
    endcase
  end

  always_comb begin
    o_cont_clr = 1'b1;
    o_cont_ld  = 1'b1;
    o_cont_en  = 1'b0;
    o_registra = 1'b0;
    o_ganhou   = 1'b0;
    o_perdeu   = 1'b0;
    o_timeout  = 1'b0;
    case (r_estado)
      S_INICIAL:     o_cont_clr = 1'b0;
      S_PREPARACAO:  o_cont_ld  = 1'b0;
      S_REGISTRA:    o_registra = 1'b1;
      S_PROXIMO:     o_cont_en  = 1'b1;
      S_FIM_ACERTO:  o_ganhou   = 1'b1;
      S_FIM_ERRO:    o_perdeu   = 1'b1;
      S_FIM_TIMEOUT: o_timeout  = 1'b1;
      default:       o_cont_clr = 1'b1;
    endcase
    o_pronto = o_ganhou | o_perdeu | o_timeout;
  end

  assign o_cont_D    = START_POS;
  assign o_db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle_rodada.sv
// tb/tb_unidade_controle_rodada.sv - directed self-checking bench for unidade_controle_rodada
module tb_unidade_controle_rodada;

  logic       clk = 1'b0;
  logic       clr;
  logic       iniciar, jogada, acertou, fim_seq, meio_seq, modo_meio;
  logic       cont_clr, cont_ld, cont_en, registra, pronto, ganhou, perdeu, timeout;
  logic [3:0] cont_D, db_estado;

  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0;
  int reg_cnt = 0;

  unidade_controle_rodada #(.TIMEOUT_CYCLES(8), .START_POS(4'd0)) dut (
    .i_clock(clk), .i_clr(clr), .i_iniciar(iniciar), .i_jogada(jogada),
    .i_acertou(acertou), .i_fim_seq(fim_seq), .i_meio_seq(meio_seq),
    .i_modo_meio(modo_meio), .o_cont_clr(cont_clr), .o_cont_ld(cont_ld),
    .o_cont_D(cont_D), .o_cont_en(cont_en), .o_registra(registra),
    .o_pronto(pronto), .o_ganhou(ganhou), .o_perdeu(perdeu),
    .o_timeout(timeout), .o_db_estado(db_estado)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle, independent of the directed steps.
  always @(negedge clk) begin
    if (cont_en === 1'b1) en_cnt = en_cnt + 1;
    if (registra === 1'b1) reg_cnt = reg_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] st, input logic [3:0] flags);
    chk({tag, "_estado"}, {12'd0, db_estado}, {12'd0, st});
    chk({tag, "_flags"}, {12'd0, pronto, ganhou, perdeu, timeout}, {12'd0, flags});
  endtask

  // One move from espera; if not final, checks proximo and returns to espera.
  task automatic move(input logic ac, input logic fs, input logic ms, input logic final_move);
    jogada = 1'b1; acertou = ac; fim_seq = fs; meio_seq = ms;
    tick();
    jogada = 1'b0;
    chk("mv_registra", {15'd0, registra}, 16'd1);
    tick();
    chk("mv_comparacao", {12'd0, db_estado}, 16'h4);
    tick();
    fim_seq = 1'b0; meio_seq = 1'b0;
    if (!final_move) begin
      chk("mv_proximo", {11'd0, db_estado, cont_en}, {11'd0, 4'h5, 1'b1});
      tick();
      chk("mv_espera", {12'd0, db_estado}, 16'h2);
    end
  endtask

  task automatic restart();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("rs_prep", {11'd0, db_estado, cont_ld}, {11'd0, 4'h1, 1'b0});
    chk("rs_flags", {15'd0, pronto}, 16'd0);
    tick();
    chk("rs_espera", {12'd0, db_estado}, 16'h2);
  endtask

  initial begin
    clr = 1'b0; iniciar = 1'b0; jogada = 1'b0; acertou = 1'b0;
    fim_seq = 1'b0; meio_seq = 1'b0; modo_meio = 1'b0;
    tick();
    chk("rst_clr_ld_en", {13'd0, cont_clr, cont_ld, cont_en}, {13'd0, 3'b010});
    chk("rst_registra", {15'd0, registra}, 16'd0);
    chk("rst_D", {12'd0, cont_D}, 16'd0);
    chk_flags("rst", 4'h0, 4'b0000);
    clr = 1'b1;
    tick();
    chk("idle_hold", {12'd0, db_estado}, 16'h0);
    restart();

    // Full-sequence win: 15 correct moves, fim_seq on the last compare.
    en_cnt = 0;
    for (int i = 1; i <= 14; i++) move(1'b1, 1'b0, 1'b0, 1'b0);
    move(1'b1, 1'b1, 1'b0, 1'b1);
    chk_flags("win", 4'hA, 4'b1100);
    chk("win_en_cnt", 16'(en_cnt), 16'd14);
    chk("win_clr", {15'd0, cont_clr}, 16'd1);
    tick();
    chk("win_hold", {12'd0, db_estado}, 16'hA);

    // Half mode: fim_seq is ignored, meio_seq on the 7th compare ends the round.
    restart();
    modo_meio = 1'b1;
    en_cnt = 0;
    move(1'b1, 1'b0, 1'b0, 1'b0);
    move(1'b1, 1'b0, 1'b0, 1'b0);
    move(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 4; i <= 6; i++) move(1'b1, 1'b0, 1'b0, 1'b0);
    move(1'b1, 1'b0, 1'b1, 1'b1);
    chk_flags("half", 4'hA, 4'b1100);
    chk("half_en_cnt", 16'(en_cnt), 16'd6);

    // Wrong third move.
    modo_meio = 1'b0;
    restart();
    en_cnt = 0;
    move(1'b1, 1'b0, 1'b0, 1'b0);
    move(1'b1, 1'b0, 1'b0, 1'b0);
    move(1'b0, 1'b0, 1'b0, 1'b1);
    chk_flags("err", 4'hE, 4'b1010);
    chk("err_en_cnt", 16'(en_cnt), 16'd2);
    restart();

    // iniciar in espera and jogada in comparacao are ignored.
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("ign_iniciar", {12'd0, db_estado}, 16'h2);
    reg_cnt = 0;
    jogada = 1'b1; acertou = 1'b1;
    tick();
    jogada = 1'b0;
    tick();
    chk("ign_comp", {12'd0, db_estado}, 16'h4);
    jogada = 1'b1;
    tick();
    jogada = 1'b0;
    chk("ign_proximo", {12'd0, db_estado}, 16'h5);
    tick();
    chk("ign_espera", {12'd0, db_estado}, 16'h2);
    chk("ign_reg_cnt", 16'(reg_cnt), 16'd1);

    // Timeout after 8 idle cycles in espera.
    for (int i = 0; i < 7; i++) tick();
    chk("to_before", {12'd0, db_estado}, 16'h2);
    tick();
    chk_flags("to", 4'hF, 4'b1001);

    // Move on the 8th cycle beats the expiry.
    restart();
    for (int i = 0; i < 7; i++) tick();
    chk("tj_before", {12'd0, db_estado}, 16'h2);
    move(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tj_flags", {15'd0, pronto}, 16'd0);

    // Asynchronous reset mid-round.
    #2 clr = 1'b0;
    #1;
    chk_flags("arst", 4'h0, 4'b0000);
    chk("arst_clr", {15'd0, cont_clr}, 16'd0);
    tick();
    clr = 1'b1;
    tick();
    chk("arst_idle", {12'd0, db_estado}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
